// File: rtl/u2_pkg.sv
// Shared definitions for the bit-serial two's-complement subtractor:
// default operand width, FSM state type and the full-adder carry helper.
package u2_pkg;

    localparam int unsigned U2_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } u2_state_e;

    // Majority of three inputs: carry out of a full adder.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/u2_fa_bit.sv
// One-bit full-adder cell, reused every SHIFT cycle by u2_serial_sub.
module u2_fa_bit
    import u2_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Pure combinational sum and carry.
    assign sum  = a ^ b ^ cin;
    assign cout = maj3(a, b, cin);

endmodule

// File: rtl/u2_serial_sub.sv
// Bit-serial two's-complement subtractor: diff = a - b, computed LSB first
// as a + ~b + 1 through a single full-adder cell, one bit per clock.
// Optional feature: define U2_SUB_SAT_EN to saturate diff on signed overflow.
module u2_serial_sub
    import u2_pkg::*;
#(
    parameter int unsigned WIDTH = U2_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             ovf,
    output logic             borrow
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    // Elaboration-time guard on the supported width range.
    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
        $error("u2_serial_sub: WIDTH must be in 2..32");
    end

    u2_state_e          state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   nb_q, nb_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               ovf_q, ovf_d;
    logic               borrow_q, borrow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               fa_sum;
    logic               fa_cout;
    logic               last_bit;
    logic               ovf_c;
    logic [WIDTH-1:0]   wrapped;
    logic [WIDTH-1:0]   commit_diff;

    // Single shared adder cell fed by the operand LSBs and the running carry.
    u2_fa_bit u_fa (
        .a    (a_q[0]),
        .b    (nb_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Final-bit detection and the result that would commit on entry to DONE.
    always_comb begin
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));
        wrapped  = {fa_sum, res_q[WIDTH-1:1]};
        // On the last bit carry_q is the carry into the MSB.
        ovf_c    = carry_q ^ fa_cout;
    end

`ifdef U2_SUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Clamp toward the sign of a; a_q[0] holds the original minuend MSB on the last bit.
    always_comb begin
        commit_diff = wrapped;
        if (ovf_c) begin
            commit_diff = a_q[0] ? SAT_NEG : SAT_POS;
        end
    end
`else
    // Plain modulo-2^WIDTH result.
    always_comb begin
        commit_diff = wrapped;
    end
`endif

    // Next-state, datapath and output decode.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        nb_d     = nb_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        diff_d   = diff_q;
        ovf_d    = ovf_q;
        borrow_d = borrow_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SHIFT;
                    a_d     = a;
                    nb_d    = ~b;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_d     = a_q >> 1;
                nb_d    = nb_q >> 1;
                carry_d = fa_cout;
                res_d   = wrapped;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    state_d  = DONE;
                    diff_d   = commit_diff;
                    ovf_d    = ovf_c;
                    borrow_d = ~fa_cout;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            nb_q     <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            ovf_q    <= 1'b0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            nb_q     <= nb_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            ovf_q    <= ovf_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign ovf    = ovf_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_u2_serial_sub.sv
// Directed bench for u2_serial_sub at WIDTH=4; honours U2_SUB_SAT_EN.
module tb_u2_serial_sub;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [3:0] diff;
    logic       ovf;
    logic       borrow;

    int n_tests = 0;
    int n_fail  = 0;

    u2_serial_sub #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .ovf    (ovf),
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Golden model from signed/unsigned integer arithmetic.
    task automatic model(input int ai, input int bi,
                         output logic [3:0] d, output logic o, output logic br);
        int sa, sb, r;
        logic [31:0] rv;
        sa = (ai >= 8) ? ai - 16 : ai;
        sb = (bi >= 8) ? bi - 16 : bi;
        r  = sa - sb;
        rv = 32'(r);
        o  = (r > 7) || (r < -8);
        br = (ai < bi);
        d  = rv[3:0];
`ifdef U2_SUB_SAT_EN
        if (o) d = (sa >= 0) ? 4'h7 : 4'h8;
`endif
    endtask

    // Called at a negedge: pulses start, waits (bounded) for done, checks latency and results.
    task automatic run_op(input logic [3:0] ai, input logic [3:0] bi, input string tag,
                          input logic [3:0] ed, input logic eo, input logic eb);
        int lat;
        start = 1'b1;
        a     = ai;
        b     = bi;
        lat   = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
        end while (!done && lat < 20);
        check({tag, " latency"}, 32'(lat), 32'd5);
        check({tag, " diff"},    32'(diff),   32'(ed));
        check({tag, " ovf"},     32'(ovf),    32'(eo));
        check({tag, " borrow"},  32'(borrow), 32'(eb));
    endtask

    initial begin
        logic [3:0] ed, prev_d;
        logic       eo, eb;
        logic       saw_done;

        rst_n = 1'b0;
        start = 1'b0;
        a     = 4'h0;
        b     = 4'h0;
        repeat (2) @(negedge clk);
        check("reset busy",   32'(busy),   32'd0);
        check("reset done",   32'(done),   32'd0);
        check("reset diff",   32'(diff),   32'd0);
        check("reset ovf",    32'(ovf),    32'd0);
        check("reset borrow", 32'(borrow), 32'd0);

        // Release and start in the same slot: first edge after release accepts.
        rst_n = 1'b1;
        start = 1'b1;
        a     = 4'h3;
        b     = 4'hE;
        @(negedge clk);
        start = 1'b0;
        check("busy rises after start", 32'(busy), 32'd1);
        check("no done in first shift", 32'(done), 32'd0);
        repeat (4) @(negedge clk);
        check("3-(-2) done at cycle 5", 32'(done),   32'd1);
        check("3-(-2) busy low in done", 32'(busy),  32'd0);
        check("3-(-2) diff",            32'(diff),   32'd5);
        check("3-(-2) ovf",             32'(ovf),    32'd0);
        check("3-(-2) borrow",          32'(borrow), 32'd1);
        @(negedge clk);
        check("done is single pulse", 32'(done), 32'd0);
        check("result held in idle",  32'(diff), 32'd5);

`ifdef U2_SUB_SAT_EN
        run_op(4'h7, 4'hF, "7-(-1)", 4'h7, 1'b1, 1'b1);
`else
        run_op(4'h7, 4'hF, "7-(-1)", 4'h8, 1'b1, 1'b1);
`endif
        run_op(4'h0, 4'h0, "0-0", 4'h0, 1'b0, 1'b0);
`ifdef U2_SUB_SAT_EN
        prev_d = 4'h8;
`else
        prev_d = 4'h7;
`endif
        run_op(4'h8, 4'h1, "-8-1", prev_d, 1'b1, 1'b0);

        // Start held through SHIFT is ignored; start in DONE chains directly.
        start = 1'b1;
        a     = 4'h5;
        b     = 4'h2;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                a = 4'h7;
                b = 4'h1;
            end
            if (k == 2) begin
                check("no partial diff in shift", 32'(diff), 32'(prev_d));
                check("busy in shift",            32'(busy), 32'd1);
            end
            if (k == 4) begin
                a = 4'h1;
                b = 4'h4;
            end
            if (k == 5) begin
                check("5-2 done",   32'(done),   32'd1);
                check("5-2 diff",   32'(diff),   32'd3);
                check("5-2 ovf",    32'(ovf),    32'd0);
                check("5-2 borrow", 32'(borrow), 32'd0);
            end
            if (k == 6) begin
                start = 1'b0;
                check("back-to-back busy", 32'(busy), 32'd1);
                check("back-to-back no done", 32'(done), 32'd0);
            end
            if (k == 10) begin
                check("1-4 done 5 cycles later", 32'(done),   32'd1);
                check("1-4 diff",                32'(diff),   32'hD);
                check("1-4 ovf",                 32'(ovf),    32'd0);
                check("1-4 borrow",              32'(borrow), 32'd1);
            end
        end

        // Abort mid-operation with reset.
        @(negedge clk);
        start = 1'b1;
        a     = 4'h6;
        b     = 4'h3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy",   32'(busy),   32'd0);
        check("abort done",   32'(done),   32'd0);
        check("abort diff",   32'(diff),   32'd0);
        check("abort ovf",    32'(ovf),    32'd0);
        check("abort borrow", 32'(borrow), 32'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        check("no done after abort", 32'(saw_done), 32'd0);
        run_op(4'h6, 4'h3, "6-3 after abort", 4'h3, 1'b0, 1'b0);

        // Full operand sweep, back-to-back.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                model(ai, bi, ed, eo, eb);
                run_op(4'(ai), 4'(bi), $sformatf("sweep a=%0d b=%0d", ai, bi), ed, eo, eb);
            end
        end
        @(negedge clk);
        check("idle after sweep done", 32'(done), 32'd0);
        check("idle after sweep busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/u2_serial_sub.md
U2_SERIAL_SUB -- requirements
Module: u2_serial_sub

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits (two's complement, U2); legal range 2..32.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset. Ports: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-003 Ports: start  input  1  request to load operands and begin a subtraction.
REQ-004 Ports: a  input  WIDTH  minuend (U2); b  input  WIDTH  subtrahend (U2), both sampled only when start is accepted.
REQ-005 Ports: busy  output  1  high while bits are being processed.
REQ-006 Ports: done  output  1  single-cycle pulse; result outputs are valid from this cycle.
REQ-007 Ports: diff  output  WIDTH  result a - b (U2); ovf  output  1  signed overflow; borrow  output  1  unsigned borrow (inverted final carry).

Function
REQ-008 States SHALL be IDLE, SHIFT and DONE; reset state is IDLE.
REQ-009 A start SHALL be accepted only in IDLE or DONE; start in SHIFT SHALL be ignored, with no effect on state, operands or results.
REQ-010 On acceptance: latch a, latch ~b, set carry to 1, clear the bit counter and enter SHIFT; busy SHALL rise on the next cycle.
REQ-011 Each SHIFT cycle SHALL process one bit, LSB first, through one full-adder cell: sum = a ^ ~b ^ c; c_next = majority(a, ~b, c).
REQ-012 Each sum bit SHALL shift in at the MSB of the result register, so that diff is complete after WIDTH SHIFT cycles.
REQ-013 The SHIFT state SHALL last exactly WIDTH cycles, then move to DONE; done SHALL assert WIDTH+1 cycles after the cycle in which start was sampled.
REQ-014 ovf SHALL equal (carry into MSB) XOR (carry out of MSB); borrow SHALL equal NOT (carry out of MSB).
REQ-015 diff, ovf and borrow SHALL hold their values from DONE until the next accepted start.
REQ-016 diff, ovf and borrow SHALL NOT show partial results during SHIFT: results commit from a shadow register on entry to DONE.
REQ-017 DONE SHALL last one cycle and then move to IDLE, unless start is high in DONE; in that case the block SHALL re-enter SHIFT directly, giving back-to-back operation with no IDLE gap.
REQ-018 The operation SHALL wrap around modulo 2^WIDTH, with no sign extension, unless the macro in REQ-022 is defined.

Reset
REQ-019 While rst_n is low: state is IDLE; busy, done, ovf and borrow are 0; diff is 0; internal operand, carry and counter registers are 0.
REQ-020 Reset asserted mid-operation SHALL abort the operation immediately; no done pulse SHALL follow, and outputs SHALL read the reset values.
REQ-021 After rst_n deasserts, the first rising edge SHALL be able to accept start.

Configuration
REQ-022 Macro U2_SUB_SAT_EN: when defined, on ovf=1 diff SHALL saturate to +max (0111..1) if a is non-negative, else to -min (1000..0); ovf still reports 1. When not defined, diff is the wrapped result and no saturation logic is present.

Structure
REQ-023 Shared package u2_pkg SHALL hold the state enum type (IDLE/SHIFT/DONE) and the default width constant U2_WIDTH_DEFAULT = 4.
REQ-024 The one-bit full-adder cell SHALL be a separate sub-module, u2_fa_bit, with ports a, b, cin, sum and cout; it is instantiated once and reused each cycle.

Verification (WIDTH=4)
REQ-025 a=3, b=-2, start pulse -> done at cycle 5; diff=5, ovf=0, borrow=1.
REQ-026 a=7, b=-1 -> diff=-8 (1000), ovf=1; with U2_SUB_SAT_EN -> diff=7 (0111), ovf=1.
REQ-027 a=-8, b=1 -> diff=7, ovf=1; with U2_SUB_SAT_EN -> diff=-8, ovf=1; also a=0, b=0 -> diff=0, ovf=0, borrow=0.
REQ-028 start=1 with a=5, b=2, then start held high with new operands during SHIFT -> only 5-2=3 is reported; a start in the DONE cycle with a=1, b=4 -> second done exactly 5 cycles later with diff=-3.
REQ-029 rst_n pulled low at SHIFT cycle 2 -> busy=0 immediately, no done pulse, diff=0; a fresh start after release completes normally.
REQ-030 Exhaustive sweep over all 256 (a,b) pairs -> diff, ovf and borrow match a golden model in both macro builds.
